// File: rtl/bit_word_packer.sv
// Packs IN_WIDTH-bit beats LSB-first into WIDTH-bit words, one word per frame or per full word.
// A short final word is zero-padded so the downstream popcount sees only real data bits.
module bit_word_packer #(
    parameter int WIDTH    = 128,
    parameter int IN_WIDTH = 16
) (
    input  logic                                clk_i,
    input  logic                                srst_i,
    input  logic [IN_WIDTH-1:0]                 data_i,
    input  logic                                data_val_i,
    input  logic                                last_i,
    output logic [WIDTH-1:0]                    data_o,
    output logic                                data_val_o,
    output logic [$clog2(WIDTH/IN_WIDTH):0]     beats_o
);

    localparam int BEATS = WIDTH / IN_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BW    = $clog2(BEATS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [IDX_W-1:0] idx_p0;
    logic [WIDTH-1:0] acc_p0;
    logic [WIDTH-1:0] merged_p0;
    logic             complete_p0;

    logic [WIDTH-1:0] word_p1;
    logic [BW-1:0]    beats_p1;
    logic             vld_p1;

    // Stage 0: drop the incoming beat into its slot; upper slots are already zero
    always_comb begin
        merged_p0 = acc_p0;
        for (int k = 0; k < BEATS; k++) begin
            if (idx_p0 == IDX_W'(k)) begin
                merged_p0[k*IN_WIDTH +: IN_WIDTH] = data_i;
            end
        end
        complete_p0 = data_val_i && ((idx_p0 == LAST_IDX) || last_i);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            idx_p0 <= '0;
            acc_p0 <= '0;
        end else if (complete_p0) begin
            idx_p0 <= '0;
            acc_p0 <= '0;
        end else if (data_val_i) begin
            idx_p0 <= idx_p0 + 1'b1;
            acc_p0 <= merged_p0;
        end
    end

    // Stage 1: registered output word; data and count hold between pulses
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            vld_p1   <= 1'b0;
            word_p1  <= '0;
            beats_p1 <= '0;
        end else begin
            vld_p1 <= complete_p0;
            if (complete_p0) begin
                word_p1  <= merged_p0;
                beats_p1 <= BW'(idx_p0) + 1'b1;
            end
        end
    end

    assign data_o     = word_p1;
    assign data_val_o = vld_p1;
    assign beats_o    = beats_p1;

endmodule

// File: tb/tb_bit_word_packer.sv
// Scoreboard bench for bit_word_packer (WIDTH=128, IN_WIDTH=16): stimulus pushes
// expected words with their due cycle, a negedge monitor pops and compares.
module tb_bit_word_packer;

    localparam int WIDTH    = 128;
    localparam int IN_WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [3:0]       beats;
        int               due;
    } exp_t;

    logic                clk = 1'b0;
    logic                srst_i = 1'b1;
    logic [IN_WIDTH-1:0] data_i = '0;
    logic                data_val_i = 1'b0;
    logic                last_i = 1'b0;
    logic [WIDTH-1:0]    data_o;
    logic                data_val_o;
    logic [3:0]          beats_o;

    exp_t             sb[$];
    int               checks = 0;
    int               passes = 0;
    int               cyc = 0;
    logic [WIDTH-1:0] hold_data = '0;
    logic [3:0]       hold_beats = '0;

    logic [WIDTH-1:0] m_acc;
    int               m_idx;

    bit_word_packer #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH)) dut (
        .clk_i      (clk),
        .srst_i     (srst_i),
        .data_i     (data_i),
        .data_val_i (data_val_i),
        .last_i     (last_i),
        .data_o     (data_o),
        .data_val_o (data_val_o),
        .beats_o    (beats_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic ok, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every pulse must match the head of the scoreboard; between pulses outputs hold
    always @(negedge clk) begin
        if (!srst_i) begin
            if (data_val_o) begin
                if (sb.size() == 0) begin
                    check("spurious_pulse", 1'b0, data_o, '0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("data_o", data_o === e.data, data_o, e.data);
                    check("beats_o", beats_o === e.beats, WIDTH'(beats_o), WIDTH'(e.beats));
                    check("latency", cyc == e.due, WIDTH'(cyc), WIDTH'(e.due));
                    hold_data  = e.data;
                    hold_beats = e.beats;
                end
            end else begin
                check("hold_data", data_o === hold_data, data_o, hold_data);
                check("hold_beats", beats_o === hold_beats, WIDTH'(beats_o), WIDTH'(hold_beats));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            data_val_i = 1'b0;
            data_i     = IN_WIDTH'($urandom);
            last_i     = 1'($urandom);
            @(posedge clk); #1;
        end
        data_val_i = 1'b0;
        last_i     = 1'b0;
    endtask

    // Drives one accepted beat; returns the cycle at which its pulse (if any) should be seen
    task automatic beat(input logic [IN_WIDTH-1:0] d, input logic l, output int due);
        due        = cyc + 1;
        data_i     = d;
        data_val_i = 1'b1;
        last_i     = l;
        @(posedge clk); #1;
        data_val_i = 1'b0;
        last_i     = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [3:0] b, input int due);
        exp_t e;
        e.data = d; e.beats = b; e.due = due;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        srst_i = 1'b1;
        @(posedge clk); #1;
        srst_i     = 1'b0;
        hold_data  = '0;
        hold_beats = '0;
        m_acc      = '0;
        m_idx      = 0;
    endtask

    // Model beat for random frames: independent packing of the beat list
    task automatic model_beat(input logic [IN_WIDTH-1:0] d, input logic l);
        int due;
        beat(d, l, due);
        m_acc[m_idx*IN_WIDTH +: IN_WIDTH] = d;
        if (m_idx == 7 || l) begin
            push(m_acc, 4'(m_idx + 1), due);
            m_acc = '0;
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    initial begin
        int due;
        m_acc = '0;
        m_idx = 0;
        repeat (3) @(posedge clk);
        #1 srst_i = 1'b0;
        @(negedge clk);
        check("rst_val", data_val_o === 1'b0, WIDTH'(data_val_o), '0);
        check("rst_data", data_o === '0, data_o, '0);
        check("rst_beats", beats_o === '0, WIDTH'(beats_o), '0);
        @(posedge clk); #1;

        // Full word, back-to-back
        for (int k = 1; k <= 8; k++) beat(16'(k), k == 8, due);
        push(128'h0008_0007_0006_0005_0004_0003_0002_0001, 4'd8, due);
        idle(3);

        // Short frame of three all-ones beats
        for (int k = 1; k <= 3; k++) beat(16'hFFFF, k == 3, due);
        push(128'h0000_0000_0000_0000_0000_FFFF_FFFF_FFFF, 4'd3, due);
        idle(2);
        check("popcount48", $countones(hold_data) == 48, WIDTH'($countones(hold_data)), 128'd48);

        // Gapped: same word, 8 beats with random idle gaps, no last_i
        for (int k = 1; k <= 8; k++) begin
            idle($urandom_range(0, 2));
            beat(16'(k), 1'b0, due);
        end
        push(128'h0008_0007_0006_0005_0004_0003_0002_0001, 4'd8, due);
        idle(3);

        // Four single-beat frames on consecutive cycles
        for (int k = 0; k < 4; k++) begin
            beat(16'hA5A5, 1'b1, due);
            push(128'h0000_0000_0000_0000_0000_0000_0000_A5A5, 4'd1, due);
        end
        idle(3);

        // Reset mid-frame discards partial word
        for (int k = 0; k < 5; k++) beat(16'h2222 + 16'(k), 1'b0, due);
        do_reset();
        for (int k = 1; k <= 8; k++) beat(16'h1111, 1'b0, due);
        push({8{16'h1111}}, 4'd8, due);
        idle(3);

        // Completing beat coincident with reset must not emit
        beat(16'h3333, 1'b0, due);
        srst_i = 1'b1;
        beat(16'h4444, 1'b1, due);
        srst_i = 1'b0;
        hold_data = '0; hold_beats = '0;
        idle(3);
        check("no_pulse_after_rst", data_o === '0, data_o, '0);

        // Random frames
        m_acc = '0; m_idx = 0;
        for (int f = 0; f < 200; f++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
                model_beat(16'($urandom), (k == len - 1) && ($urandom_range(0, 3) != 0));
            end
        end
        idle(5);
        check("sb_empty", sb.size() == 0, WIDTH'(sb.size()), '0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
